// File: rtl/square_motion_if.sv
// Bus between the VGA animated-square motion controller and its environment:
// raw push buttons and pixel counters in, square position and status out.
interface square_motion_if;
  logic [3:0] push;        // raw buttons: [0] right, [1] left, [2] down, [3] up
  logic [9:0] pixel_x;     // current pixel column from the sync generator
  logic [9:0] pixel_y;     // current pixel row from the sync generator
  logic [9:0] square_x;    // square left edge
  logic [9:0] square_y;    // square top edge
  logic       frame_tick;  // one-cycle pulse per frame
  logic       moving;      // one-cycle pulse when the position changes
  logic [1:0] dir;         // latched direction (0 R, 1 L, 2 D, 3 U)

  // Environment side: drives buttons and pixel counters.
  modport master (
    output push, pixel_x, pixel_y,
    input  square_x, square_y, frame_tick, moving, dir
  );

  // Controller side.
  modport slave (
    input  push, pixel_x, pixel_y,
    output square_x, square_y, frame_tick, moving, dir
  );
endinterface

// File: rtl/square_motion_ctrl.sv
// Motion controller for the VGA animated square.
// Debounces the four push buttons, derives one tick per frame from the pixel
// counters (during vertical blank), arbitrates direction and steps the
// square's top-left position with single-step / auto-repeat behaviour.
// Optional feature: define AUTO_BOUNCE_EN to add an idle auto-bounce mode.
module square_motion_ctrl #(
  parameter int MAX_X        = 640,
  parameter int MAX_Y        = 480,
  parameter int SQUARE_SIZE  = 40,
  parameter int SQUARE_VEL   = 5,
  parameter int INIT_X       = 320,
  parameter int INIT_Y       = 240,
  parameter int TICK_Y       = 481,
  parameter int DEB_CYCLES   = 250000,
  parameter int REPEAT_DELAY = 15,
  parameter int IDLE_FRAMES  = 300
) (
  input  logic            clk,
  input  logic            rst,   // asynchronous, active-low
  square_motion_if.slave  bus
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_DELAY + 1);

  // Reject parameter sets the step arithmetic cannot handle.
  if (DEB_CYCLES < 1 || REPEAT_DELAY < 1 || IDLE_FRAMES < 1 ||
      SQUARE_SIZE + SQUARE_VEL > MAX_X || SQUARE_SIZE + SQUARE_VEL > MAX_Y ||
      MAX_X > 1023 || MAX_Y > 1023) begin : g_bad_params
    $error("square_motion_ctrl: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_REPEAT = 2'd2
`ifdef AUTO_BOUNCE_EN
    , S_BOUNCE = 2'd3
`endif
  } state_e;

  // Position one step towards the far edge, clamped so the square stays inside.
  // The sum is formed in 11 bits so it cannot wrap.
  function automatic logic [9:0] inc_clamp(input logic [9:0] p, input int lim);
    logic [10:0] reach;
    reach = {1'b0, p} + 11'(SQUARE_SIZE + SQUARE_VEL);
    if (reach <= 11'(lim)) inc_clamp = p + 10'(SQUARE_VEL);
    else                   inc_clamp = 10'(lim - SQUARE_SIZE);
  endfunction

  // Position one step towards zero, clamped at zero.
  function automatic logic [9:0] dec_clamp(input logic [9:0] p);
    if (p >= 10'(SQUARE_VEL)) dec_clamp = p - 10'(SQUARE_VEL);
    else                      dec_clamp = '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Frame tick
  // ---------------------------------------------------------------------------
  logic match_q, match_dly_q;
  logic frame_tick;

  // Register the tick-line match and its delayed copy for edge detection.
  // NOTE: state is updated with non-blocking (<=) assignments so every flop
  // samples pre-edge values; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q     <= 1'b0;
      match_dly_q <= 1'b0;
    end else begin
      match_q     <= (bus.pixel_y == 10'(TICK_Y)) && (bus.pixel_x == 10'd0);
      match_dly_q <= match_q;
    end
  end

  assign frame_tick = match_q & ~match_dly_q;

  // ---------------------------------------------------------------------------
  // Button synchronisers and debouncers
  // ---------------------------------------------------------------------------
  logic [3:0]       sync1_q, sync2_q, db_q;
  logic [DEB_W-1:0] deb_cnt_q [4];

  // Two-flop synchroniser, then flip db only after DEB_CYCLES disagreeing cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= bus.push;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
            db_q[i]      <= ~db_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Movement FSM and position registers
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [REP_W-1:0] cnt_q, cnt_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             moving_q, moving_d;
  logic [1:0]       win;
  logic             step_en;
  logic [1:0]       step_dir;
`ifdef AUTO_BOUNCE_EN
  localparam int IDLE_W = $clog2(IDLE_FRAMES + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              fx_q, fx_d, fy_q, fy_d;  // 1 = moving towards +x / +y
`endif

  // State, direction, repeat counter and position registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      dir_q    <= 2'd0;
      cnt_q    <= '0;
      x_q      <= 10'(INIT_X);
      y_q      <= 10'(INIT_Y);
      moving_q <= 1'b0;
`ifdef AUTO_BOUNCE_EN
      idle_q   <= '0;
      fx_q     <= 1'b1;
      fy_q     <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      moving_q <= moving_d;
`ifdef AUTO_BOUNCE_EN
      idle_q   <= idle_d;
      fx_q     <= fx_d;
      fy_q     <= fy_d;
`endif
    end
  end

  // Next-state, arbitration and step arithmetic.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    step_en  = 1'b0;
    step_dir = dir_q;
`ifdef AUTO_BOUNCE_EN
    idle_d   = idle_q;
    fx_d     = fx_q;
    fy_d     = fy_q;
`endif

    // Fixed priority: right > left > down > up.
    if (db_q[0])      win = 2'd0;
    else if (db_q[1]) win = 2'd1;
    else if (db_q[2]) win = 2'd2;
    else              win = 2'd3;

    case (state_q)
      S_IDLE: begin
        if (frame_tick && |db_q) begin
          step_en  = 1'b1;
          step_dir = win;
          dir_d    = win;
          cnt_d    = '0;
          state_d  = S_WAIT;
        end
`ifdef AUTO_BOUNCE_EN
        else if (frame_tick && !(|db_q)) begin
          if (idle_q == IDLE_W'(IDLE_FRAMES - 1)) begin
            idle_d  = '0;
            state_d = S_BOUNCE;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
`endif
      end
      S_WAIT: begin
        if (frame_tick) begin
          if (!db_q[dir_q])                          state_d = S_IDLE;
          else if (cnt_q == REP_W'(REPEAT_DELAY - 1)) state_d = S_REPEAT;
          else                                       cnt_d = cnt_q + 1'b1;
        end
      end
      S_REPEAT: begin
        if (frame_tick) begin
          if (db_q[dir_q]) step_en = 1'b1;
          else             state_d = S_IDLE;
        end
      end
`ifdef AUTO_BOUNCE_EN
      S_BOUNCE: begin
        if (|db_q) begin
          state_d = S_IDLE;
        end else if (frame_tick) begin
          if (fx_q) begin
            x_d = inc_clamp(x_q, MAX_X);
            if (x_d == 10'(MAX_X - SQUARE_SIZE)) fx_d = 1'b0;
          end else begin
            x_d = dec_clamp(x_q);
            if (x_d == 10'd0) fx_d = 1'b1;
          end
          if (fy_q) begin
            y_d = inc_clamp(y_q, MAX_Y);
            if (y_d == 10'(MAX_Y - SQUARE_SIZE)) fy_d = 1'b0;
          end else begin
            y_d = dec_clamp(y_q);
            if (y_d == 10'd0) fy_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef AUTO_BOUNCE_EN
    if (|db_q) idle_d = '0;
`endif

    if (step_en) begin
      case (step_dir)
        2'd0:    x_d = inc_clamp(x_q, MAX_X);
        2'd1:    x_d = dec_clamp(x_q);
        2'd2:    y_d = inc_clamp(y_q, MAX_Y);
        default: y_d = dec_clamp(y_q);
      endcase
    end

    // A clamped step that leaves the position unchanged does not pulse.
    moving_d = (x_d != x_q) || (y_d != y_q);
  end

  assign bus.square_x   = x_q;
  assign bus.square_y   = y_q;
  assign bus.frame_tick = frame_tick;
  assign bus.moving     = moving_q;
  assign bus.dir        = dir_q;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Self-checking bench for square_motion_ctrl (DEB_CYCLES=4, REPEAT_DELAY=3).
// Directed scenarios plus a randomized phase, compared every cycle against a
// behavioural reference model kept in this file.
module tb_square_motion_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  square_motion_if bus ();

  square_motion_ctrl #(
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (RD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int mov_cnt  = 0;
  int ft_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: buttons seen two cycles late, accepted after DEB
  // consecutive disagreeing samples; a locked direction steps on its first
  // frame and then on every frame from the (RD+2)-th held frame onwards.
  // ---------------------------------------------------------------------------
  logic [3:0] m_s1, m_s2, m_db;
  int         m_run [4];
  bit         m_mq, m_mqd, m_locked, m_mov;
  int         m_held, m_dir, m_x, m_y;

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_mq = 0; m_mqd = 0; m_locked = 0; m_mov = 0;
    m_held = 0; m_dir = 0; m_x = 320; m_y = 240;
  endfunction

  function automatic void model_move(input int d);
    case (d)
      0: m_x = (m_x + 45 <= 640) ? m_x + 5 : 600;
      1: m_x = (m_x >= 5) ? m_x - 5 : 0;
      2: m_y = (m_y + 45 <= 480) ? m_y + 5 : 440;
      default: m_y = (m_y >= 5) ? m_y - 5 : 0;
    endcase
  endfunction

  function automatic void model_step(input logic [3:0] p, input bit tick);
    bit         ft;
    logic [3:0] db_old;
    int         ox, oy, w;
    if (!rst) begin
      model_reset();
      return;
    end
    ft = m_mq && !m_mqd;
    db_old = m_db;
    ox = m_x; oy = m_y;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_db[i] = ~m_db[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1; m_s1 = p;
    m_mqd = m_mq; m_mq = tick;
    if (ft) begin
      if (!m_locked) begin
        if (db_old != 0) begin
          w = 3;
          for (int i = 3; i >= 0; i--) if (db_old[i]) w = i;
          m_dir = w; m_locked = 1; m_held = 1;
          model_move(m_dir);
        end
      end else if (!db_old[m_dir]) begin
        m_locked = 0;
      end else begin
        m_held++;
        if (m_held >= RD + 2) model_move(m_dir);
      end
    end
    m_mov = (m_x != ox) || (m_y != oy);
  endfunction

  // One clock: compare outputs against the model, then drive the next inputs.
  task automatic cyc(input logic [3:0] p, input bit tick, input bit rv = 1'b1);
    @(negedge clk);
    check("square_x",   bus.square_x,   m_x);
    check("square_y",   bus.square_y,   m_y);
    check("frame_tick", bus.frame_tick, m_mq && !m_mqd);
    check("moving",     bus.moving,     m_mov);
    check("dir",        bus.dir,        m_dir);
    if (bus.moving === 1'b1)     mov_cnt++;
    if (bus.frame_tick === 1'b1) ft_cnt++;
    rst      = rv;
    bus.push = p;
    if (tick) begin
      bus.pixel_x = 10'd0;
      bus.pixel_y = 10'd481;
    end else begin
      bus.pixel_x = 10'($urandom_range(0, 799));
      bus.pixel_y = 10'($urandom_range(0, 480));
    end
    model_step(p, tick);
  endtask

  // Tick line held for 1..3 cycles, then gap cycles of ordinary pixels.
  task automatic frame(input logic [3:0] p, input int gap);
    int tl;
    tl = $urandom_range(1, 3);
    repeat (tl) cyc(p, 1'b1);
    repeat (gap) cyc(p, 1'b0);
  endtask

  task automatic do_reset();
    repeat (2) cyc(4'b0000, 1'b0, 1'b0);
    repeat (2) cyc(4'b0000, 1'b0);
    mov_cnt = 0;
    ft_cnt  = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] p;
    bus.push    = '0;
    bus.pixel_x = 10'd5;
    bus.pixel_y = 10'd5;
    model_reset();
    do_reset();

    // Tap: right held 10 cycles, tick line held 3 cycles inside it.
    repeat (7) cyc(4'b0001, 1'b0);
    repeat (3) cyc(4'b0001, 1'b1);
    repeat (20) cyc(4'b0000, 1'b0);
    frame(4'b0000, 12);
    check("tap_x", bus.square_x, 325);
    check("tap_moves", mov_cnt, 1);
    check("tap_ticks", ft_cnt, 2);

    // Hold left across 6 ticks: steps on ticks 1, 5 and 6.
    do_reset();
    repeat (8) cyc(4'b0010, 1'b0);
    repeat (6) frame(4'b0010, $urandom_range(8, 14));
    repeat (10) cyc(4'b0000, 1'b0);
    check("hold_x", bus.square_x, 305);
    check("hold_moves", mov_cnt, 3);

    // Asynchronous reset in the middle of auto-repeat.
    do_reset();
    repeat (8) cyc(4'b0001, 1'b0);
    repeat (6) frame(4'b0001, 10);
    check("pre_reset_x", bus.square_x, 335);
    #2 rst = 1'b0;
    #1;
    check("rst_x",          bus.square_x,   320);
    check("rst_y",          bus.square_y,   240);
    check("rst_frame_tick", bus.frame_tick, 0);
    check("rst_moving",     bus.moving,     0);
    check("rst_dir",        bus.dir,        0);
    model_reset();
    repeat (3) cyc(4'b0000, 1'b0, 1'b0);
    repeat (8) cyc(4'b1000, 1'b0);
    frame(4'b1000, 10);
    check("post_reset_y",   bus.square_y, 235);
    check("post_reset_dir", bus.dir, 3);

    // Clamp at the right edge: 56 moves, then no further pulses.
    do_reset();
    repeat (8) cyc(4'b0001, 1'b0);
    repeat (64) frame(4'b0001, $urandom_range(8, 12));
    check("clamp_x", bus.square_x, 600);
    check("clamp_moves", mov_cnt, 56);

    // Glitch: 3-cycle pulses never satisfy the 4-cycle debounce.
    do_reset();
    for (int k = 0; k < 30; k++)
      cyc(((k / 3) % 2 == 0) ? 4'b0100 : 4'b0000, (k == 10) || (k == 25));
    repeat (4) cyc(4'b0000, 1'b0);
    check("glitch_y", bus.square_y, 240);
    check("glitch_moves", mov_cnt, 0);
    check("glitch_ticks", ft_cnt, 2);

    // Priority and direction lock.
    do_reset();
    repeat (8) cyc(4'b0101, 1'b0);
    frame(4'b0101, 10);
    check("prio_x", bus.square_x, 325);
    check("prio_y", bus.square_y, 240);
    repeat (2) frame(4'b1101, 10);
    check("lock_x",   bus.square_x, 325);
    check("lock_dir", bus.dir, 0);
    repeat (8) cyc(4'b1100, 1'b0);
    frame(4'b1100, 10);
    check("release_y", bus.square_y, 240);
    frame(4'b1100, 10);
    check("down_y",   bus.square_y, 245);
    check("down_dir", bus.dir, 2);

    // Randomized buttons and frame timing.
    do_reset();
    p = '0;
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 3) == 0) p = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) cyc(p ^ 4'($urandom), 1'b0);
      end
      frame(p, $urandom_range(6, 14));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
